// File: rtl/lfsr_ctrl_pkg.sv
// rtl/lfsr_ctrl_pkg.sv - shared states, error codes and expected balance counts for the LFSR run controller
package lfsr_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_SEED0    = 2'd3;

  // A maximal-length W-bit sequence emits one more '1' than '0' per period.
  function automatic int unsigned exp_ones(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned exp_zeros(input int unsigned w);
    return exp_ones(w) - 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_watchdog.sv
// rtl/lfsr_watchdog.sv - clearable enabled up-counter that flags when TIMEOUT cycles have elapsed
module lfsr_watchdog #(
  parameter int unsigned TIMEOUT = 8200,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holds at LIMIT so the flag cannot wrap back to zero while the FSM reacts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/lfsr_run_ctrl.sv
// rtl/lfsr_run_ctrl.sv - sequences seed load, multi-period LFSR runs and bit-balance checking
module lfsr_run_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int unsigned W       = 13,
  parameter int unsigned PW      = 4,
  parameter int unsigned TIMEOUT = 8200
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [W-1:0]  seed_i,
  input  logic [PW-1:0] num_periods_i,
  input  logic          max_tick_i,
  input  logic [W-1:0]  count_zero_i,
  input  logic [W-1:0]  count_one_i,
  output logic          lfsr_load_o,
  output logic [W-1:0]  lfsr_seed_o,
  output logic          lfsr_en_o,
  output logic          cnt_clr_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [1:0]    err_code_o,
  output logic [W-1:0]  zeros_lat_o,
  output logic [W-1:0]  ones_lat_o,
  output logic [PW-1:0] periods_done_o
);

  localparam logic [W-1:0] EXP_ONES  = W'(exp_ones(W));
  localparam logic [W-1:0] EXP_ZEROS = W'(exp_zeros(W));

  state_e        state_q, state_d;
  logic [W-1:0]  seed_q, seed_d;
  logic [PW-1:0] nper_q, nper_d;
  logic [PW-1:0] pd_q, pd_d;
  logic [W-1:0]  zeros_q, zeros_d;
  logic [W-1:0]  ones_q, ones_d;
  logic [1:0]    err_q, err_d;
  logic          pass_q, pass_d;
  logic          load_q, load_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          expired;
  logic [PW:0]   pd_inc;

  lfsr_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (state_q != S_RUN),
    .en_i     (state_q == S_RUN),
    .expired_o(expired)
  );

  assign pd_inc = {1'b0, pd_q} + (PW+1)'(1);

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    nper_d  = nper_q;
    pd_d    = pd_q;
    zeros_d = zeros_q;
    ones_d  = ones_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pass_d = 1'b0;
          if (seed_i != '0) begin
            seed_d  = seed_i;
            nper_d  = (num_periods_i == '0) ? PW'(1) : num_periods_i;
            pd_d    = '0;
            zeros_d = '0;
            ones_d  = '0;
            err_d   = ERR_NONE;
            state_d = S_LOAD;
          end else begin
            err_d   = ERR_SEED0;
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: state_d = S_RUN;
      // A tick in the expiry cycle still wins: the period completed in time.
      S_RUN: begin
        if (max_tick_i) begin
          zeros_d = count_zero_i;
          ones_d  = count_one_i;
          state_d = S_CHECK;
        end else if (expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_CHECK: begin
        pd_d = (pd_q == {PW{1'b1}}) ? pd_q : pd_q + PW'(1);
        if ((zeros_q != EXP_ZEROS) || (ones_q != EXP_ONES)) begin
          err_d   = ERR_MISMATCH;
          state_d = S_DONE;
        end else if (pd_inc < {1'b0, nper_q}) begin
          state_d = S_RUN;
        end else begin
          pass_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Strobes follow the next state so every output leaves a flop.
    load_d = (state_d == S_LOAD);
    en_d   = (state_d == S_RUN);
    clr_d  = (state_d == S_LOAD) || (state_d == S_CHECK);
    busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      nper_q  <= '0;
      pd_q    <= '0;
      zeros_q <= '0;
      ones_q  <= '0;
      err_q   <= ERR_NONE;
      pass_q  <= 1'b0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      nper_q  <= nper_d;
      pd_q    <= pd_d;
      zeros_q <= zeros_d;
      ones_q  <= ones_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      load_q  <= load_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign lfsr_load_o    = load_q;
  assign lfsr_seed_o    = seed_q;
  assign lfsr_en_o      = en_q;
  assign cnt_clr_o      = clr_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign err_code_o     = err_q;
  assign zeros_lat_o    = zeros_q;
  assign ones_lat_o     = ones_q;
  assign periods_done_o = pd_q;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// tb/tb_lfsr_run_ctrl.sv - directed table and corner-sequence bench for lfsr_run_ctrl
module tb_lfsr_run_ctrl;

  localparam int W       = 13;
  localparam int PW      = 4;
  localparam int TIMEOUT = 8200;
  localparam int PERIOD  = 8191;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  seed = '0;
  logic [PW-1:0] num_periods = '0;
  logic          max_tick;
  logic [W-1:0]  ones_val = 13'd4096;
  logic [W-1:0]  zeros_val = 13'd4095;
  logic          lfsr_load, lfsr_en, cnt_clr, busy, done, pass;
  logic [W-1:0]  lfsr_seed, zeros_lat, ones_lat;
  logic [1:0]    err_code;
  logic [PW-1:0] periods_done;

  logic          auto_mode = 1'b0;
  logic          man_tick = 1'b0;
  logic [13:0]   dp_cnt = '0;

  int checks = 0, errors = 0, cyc = 0;
  int n_load = 0, n_check = 0, n_done = 0, n_busy = 0, n_gap = 0;
  int tick_gap = 2;
  int start_cyc, done_cyc, entry_cyc, tick_cyc;

  always #5 clk = ~clk;

  lfsr_run_ctrl dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .seed_i(seed),
    .num_periods_i(num_periods), .max_tick_i(max_tick),
    .count_zero_i(zeros_val), .count_one_i(ones_val),
    .lfsr_load_o(lfsr_load), .lfsr_seed_o(lfsr_seed), .lfsr_en_o(lfsr_en),
    .cnt_clr_o(cnt_clr), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_code_o(err_code), .zeros_lat_o(zeros_lat), .ones_lat_o(ones_lat),
    .periods_done_o(periods_done)
  );

  // Stand-in datapath: a full period is PERIOD enabled cycles after a clear.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_clr) dp_cnt <= '0;
    else if (lfsr_en) dp_cnt <= dp_cnt + 14'd1;
  end

  assign max_tick = auto_mode ? (lfsr_en && (dp_cnt == 14'(PERIOD - 1))) : man_tick;

  always @(negedge clk) begin
    if (lfsr_load) n_load <= n_load + 1;
    if (cnt_clr && !lfsr_load) n_check <= n_check + 1;
    if (done) n_done <= n_done + 1;
    if (busy) n_busy <= n_busy + 1;
    if (busy && !lfsr_en) n_gap <= n_gap + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int outs_or();
    return int'(|{lfsr_load, lfsr_seed, lfsr_en, cnt_clr, busy, done, pass,
                  err_code, zeros_lat, ones_lat, periods_done});
  endfunction

  task automatic run(input logic [W-1:0] s, input logic [PW-1:0] np, input int bound,
                     output bit got_done);
    int run_len;
    run_len = 0;
    got_done = 1'b0;
    entry_cyc = -1;
    tick_cyc = -1;
    @(posedge clk); #1;
    seed = s; num_periods = np; start = 1'b1; start_cyc = cyc;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      man_tick = 1'b0;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (lfsr_en) begin
        if (entry_cyc < 0) entry_cyc = cyc;
        if (!auto_mode && run_len == tick_gap) begin
          man_tick = 1'b1;
          tick_cyc = cyc;
          run_len = 0;
        end else begin
          run_len++;
        end
      end else begin
        run_len = 0;
      end
    end
    if (!got_done) chk("done_within_bound", 0, 1);
  endtask

  typedef struct {
    logic [W-1:0]  seed;
    logic [PW-1:0] np;
    logic [W-1:0]  ones;
    logic [W-1:0]  zeros;
    int            exp_pass;
    int            exp_err;
    int            exp_pd;
    int            exp_ones;
    int            exp_zeros;
    int            exp_loads;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit ok;
    int l0, c0, b0, g0, d0;

    tbl[0] = '{13'h0001, 4'd1,  13'd4096, 13'd4095, 1, 0, 1,  4096, 4095, 1};
    tbl[1] = '{13'h1FFF, 4'd0,  13'd4096, 13'd4095, 1, 0, 1,  4096, 4095, 1};
    tbl[2] = '{13'h00AB, 4'd2,  13'd4096, 13'd4095, 1, 0, 2,  4096, 4095, 1};
    tbl[3] = '{13'h0005, 4'd3,  13'd4095, 13'd4095, 0, 1, 1,  4095, 4095, 1};
    tbl[4] = '{13'h0007, 4'd2,  13'd4096, 13'd4096, 0, 1, 1,  4096, 4096, 1};
    tbl[5] = '{13'h0000, 4'd2,  13'd4096, 13'd4095, 0, 3, 1,  4096, 4096, 0};
    tbl[6] = '{13'h1000, 4'd15, 13'd4096, 13'd4095, 1, 0, 15, 4096, 4095, 1};
    tbl[7] = '{13'h0002, 4'd4,  13'd0,    13'd4095, 0, 1, 1,  0,    4095, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", outs_or(), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ones_val = tbl[i].ones;
      zeros_val = tbl[i].zeros;
      tick_gap = 2;
      l0 = n_load; b0 = n_busy;
      run(tbl[i].seed, tbl[i].np, 400, ok);
      chk($sformatf("v%0d_pass", i), int'(pass), tbl[i].exp_pass);
      chk($sformatf("v%0d_err", i), int'(err_code), tbl[i].exp_err);
      chk($sformatf("v%0d_periods", i), int'(periods_done), tbl[i].exp_pd);
      chk($sformatf("v%0d_ones_lat", i), int'(ones_lat), tbl[i].exp_ones);
      chk($sformatf("v%0d_zeros_lat", i), int'(zeros_lat), tbl[i].exp_zeros);
      chk($sformatf("v%0d_loads", i), n_load - l0, tbl[i].exp_loads);
      chk($sformatf("v%0d_busy_seen", i), ((n_busy - b0) > 0) ? 1 : 0,
          (tbl[i].seed != '0) ? 1 : 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
      chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
    end

    ones_val = 13'd4096; zeros_val = 13'd4095;
    run(13'h0000, 4'd1, 10, ok);
    chk("seed0_latency", done_cyc - start_cyc, 1);

    // Full-length period from the stand-in datapath.
    auto_mode = 1'b1;
    run(13'h0001, 4'd1, 9000, ok);
    chk("auto1_latency", done_cyc - start_cyc, 8194);
    chk("auto1_pass", int'(pass), 1);
    chk("auto1_err", int'(err_code), 0);
    chk("auto1_ones", int'(ones_lat), 4096);
    chk("auto1_zeros", int'(zeros_lat), 4095);
    chk("auto1_periods", int'(periods_done), 1);

    l0 = n_load; c0 = n_check; g0 = n_gap;
    run(13'h0001, 4'd3, 30000, ok);
    chk("auto3_checks", n_check - c0, 3);
    chk("auto3_loads", n_load - l0, 1);
    chk("auto3_en_gaps", n_gap - g0, 4);
    chk("auto3_pass", int'(pass), 1);
    chk("auto3_periods", int'(periods_done), 3);
    auto_mode = 1'b0;

    ones_val = 13'd4095; zeros_val = 13'd4095; tick_gap = 5;
    run(13'h0321, 4'd2, 100, ok);
    chk("mismatch_latency", done_cyc - tick_cyc, 2);
    chk("mismatch_pass", int'(pass), 0);
    chk("mismatch_err", int'(err_code), 1);

    ones_val = 13'd4096; zeros_val = 13'd4095; tick_gap = 1000000;
    run(13'h0044, 4'd1, 9000, ok);
    chk("timeout_latency", done_cyc - entry_cyc, TIMEOUT + 1);
    chk("timeout_err", int'(err_code), 2);
    chk("timeout_pass", int'(pass), 0);
    chk("timeout_ones_cleared", int'(ones_lat), 0);

    tick_gap = TIMEOUT;
    run(13'h0044, 4'd1, 9000, ok);
    chk("coincide_latency", done_cyc - entry_cyc, TIMEOUT + 2);
    chk("coincide_err", int'(err_code), 0);
    chk("coincide_pass", int'(pass), 1);

    // Reset in the middle of a run, after an ignored start.
    @(posedge clk); #1;
    seed = 13'h0123; num_periods = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("midrun_en", int'(lfsr_en), 1);
    l0 = n_load;
    seed = 13'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("ignored_start_busy", int'(busy), 1);
    chk("ignored_start_done", int'(done), 0);
    chk("ignored_start_loads", n_load - l0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", outs_or(), 0);
    d0 = n_done;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("post_reset_no_done", n_done - d0, 0);
    chk("post_reset_outputs", outs_or(), 0);
    tick_gap = 2;
    run(13'h0123, 4'd1, 100, ok);
    chk("post_reset_pass", int'(pass), 1);
    chk("post_reset_err", int'(err_code), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: actual expired required finish");
    $fatal(1);
  end

endmodule

// File: doc/lfsr_run_ctrl.md
# lfsr_run_ctrl

Run controller for the 13-bit LFSR/bit-balance datapath (the `advance` block). It loads a seed, enables the LFSR for a programmed number of full sequence periods, and latches `count_zero`/`count_one` at each `max_tick`. Each period is checked against the maximal-length balance (2^(W-1) ones, 2^(W-1)-1 zeros), and the block reports pass/fail with an error code. It sits between the top-level test/control logic and the LFSR datapath, which it sequences via load/enable/clear strobes.

## Interface
- `W`, 13: LFSR and counter width.
- `PW`, 4: width of the period-count request.
- `TIMEOUT`, 8200: RUN cycles without `max_tick` before timeout; must exceed 2^W-1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `start` in 1: begin a run; sampled only in IDLE.
- `seed` in W: LFSR seed, captured on accepted `start`.
- `num_periods` in PW: periods to check; 0 is treated as 1.
- `max_tick` in 1: datapath end-of-period strobe.
- `count_zero` in W: datapath zero count, valid when `max_tick`=1.
- `count_one` in W: datapath one count, valid when `max_tick`=1.
- `lfsr_load` out 1: one-cycle seed load strobe.
- `lfsr_seed` out W: seed presented with `lfsr_load`.
- `lfsr_en` out 1: LFSR/counter advance enable.
- `cnt_clr` out 1: synchronous clear of datapath counters.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `pass` out 1: result, valid from `done` until next accepted `start`.
- `err_code` out 2: 0 none, 1 count mismatch, 2 timeout, 3 zero seed.
- `zeros_lat` out W: last latched zero count.
- `ones_lat` out W: last latched one count.
- `periods_done` out PW: periods checked so far.

## Operation
- States: IDLE, LOAD, RUN, CHECK, DONE.
- IDLE, `start`=1:
  - `seed`≠0: capture `seed` and `num_periods`, clear `pass`/`err_code`/`periods_done`/latches, set `busy`, go to LOAD.
  - `seed`=0: go straight to DONE with `err_code`=3 and `pass`=0.
- LOAD (1 cycle): `lfsr_load`=1, `cnt_clr`=1, `lfsr_en`=0; go to RUN.
- RUN: `lfsr_en`=1; the watchdog increments each cycle.
  - `max_tick`=1: latch `count_zero`/`count_one` into `zeros_lat`/`ones_lat`, go to CHECK.
  - Watchdog reaches TIMEOUT: `err_code`=2, go to DONE.
  - `max_tick` and watchdog expiry in the same cycle: `max_tick` wins.
- CHECK (1 cycle): `lfsr_en`=0, `cnt_clr`=1, watchdog cleared, `periods_done`+1.
  - Latches ≠ expected: `err_code`=1, go to DONE.
  - Latches match and `periods_done`+1 < effective `num_periods`: return to RUN with no reload, so the LFSR continues its sequence.
  - Otherwise: `pass`=1, go to DONE.
- DONE (1 cycle): `done`=1; `busy` drops in the same cycle; go to IDLE.
- `start` outside IDLE is ignored. `pass`, `err_code`, latches and `periods_done` hold until the next accepted `start`.
- Arithmetic:
  - Expected ones = 1<<(W-1); expected zeros = (1<<(W-1))-1. Compare at full W bits.
  - `periods_done` saturates at 2^PW-1.
  - Watchdog counter width is clog2(TIMEOUT+1).
- Reset, including mid-run: every output is 0, state is IDLE, watchdog is 0. No pending `done` is emitted.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `start` accepted at edge k: LOAD at k+1, RUN (`lfsr_en`=1) from k+2.
- `max_tick` sampled at edge t: CHECK at t+1, DONE (`done`=1) at t+2 when the run ends.
- When the run continues, `lfsr_en` is 0 for exactly one cycle (CHECK) between periods.
- Zero-seed rejection: `done` one cycle after `start` is accepted; `busy` never asserts.
- Timeout: `done` one cycle after the watchdog reaches TIMEOUT.

## Structure
- Package `lfsr_ctrl_pkg` holds:
  - state encoding (IDLE=0, LOAD=1, RUN=2, CHECK=3, DONE=4);
  - `err_code` constants (ERR_NONE, ERR_MISMATCH, ERR_TIMEOUT, ERR_SEED0);
  - expected-count constants derived from W.
- One sub-module, `lfsr_watchdog`: clearable, enabled up-counter with TIMEOUT compare and an `expired` flag.

## Test plan
- Seed 13'h0001, `num_periods`=1, real `advance` datapath: `done` within 8194 cycles of `start`, `pass`=1, `err_code`=0, `ones_lat`=4096, `zeros_lat`=4095, `periods_done`=1.
- `num_periods`=3: three CHECK visits, `lfsr_load` pulses once, `pass`=1, `periods_done`=3.
- Model datapath returning `count_one`=4095 at `max_tick`: `done` 2 cycles after `max_tick`, `pass`=0, `err_code`=1.
- `max_tick` held low: `done` at RUN entry + TIMEOUT + 1 cycles, `err_code`=2. In a separate case, `max_tick` coincides with expiry: no timeout, proceeds to CHECK.
- `seed`=0: `done` one cycle after `start`, `busy` never high, `err_code`=3.
- `reset` pulse during RUN: all outputs 0 immediately; `start` during `busy` ignored; a fresh `start` after reset completes with `pass`=1.
